sprite_blitter: RTL and testbench

- Parametrised successor to the full-screen single-sprite stretcher.
- Draws one sprite from a multi-sprite ROM at a programmable screen position, with integer scaling and a transparent palette index; background pixels pass through elsewhere.
- Scale is produced by incremental counters, so there are no multipliers or dividers on DrawX/DrawY.
- Sits between the VGA controller and the board/background renderer; instances can be chained, with one instance's output feeding the next one's background input.

---
 rtl/sprite_blitter.sv | 214 +++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: scaled sprite overlay from a multi-sprite ROM.
// Frame-latched position/select, incremental scale counters, ROM-aligned pipeline.
module sprite_blitter #(
  parameter int          SPRITE_W        = 60,
  parameter int          SPRITE_H        = 60,
  parameter int          NUM_SPRITES     = 12,
  parameter int          SCALE           = 1,
  parameter int          ROM_LAT         = 1,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'd0,
  localparam int         SEL_W = $clog2(NUM_SPRITES),
  localparam int         AW    = $clog2(NUM_SPRITES*SPRITE_W*SPRITE_H)
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic [SEL_W-1:0] sprite_sel,
  input  logic [3:0]       bg_red,
  input  logic [3:0]       bg_green,
  input  logic [3:0]       bg_blue,
  output logic [AW-1:0]    rom_addr,
  input  logic [3:0]       rom_q,
  output logic [3:0]       pal_idx,
  input  logic [3:0]       pal_red,
  input  logic [3:0]       pal_green,
  input  logic [3:0]       pal_blue,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             sprite_hit
);

  localparam int CW     = $clog2(SPRITE_W + 1);
  localparam int RW     = $clog2(SPRITE_H + 1);
  localparam int SW     = $clog2(SCALE + 1);
  localparam int SPR_SZ = SPRITE_W * SPRITE_H;
  localparam logic [SW-1:0] SMAX = SW'(SCALE - 1);
  localparam logic [CW-1:0] CMAX = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(SPRITE_H - 1);
  localparam logic [AW-1:0] W_A  = AW'(SPRITE_W);

  logic [9:0]       drawy_q;
  logic             armed_q, armed_d;
  logic [9:0]       px_q, px_d;
  logic [9:0]       py_q, py_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic             v_act_q, v_act_d;
  logic [RW-1:0]    row_q, row_d;
  logic [SW-1:0]    rsub_q, rsub_d;
  logic [AW-1:0]    rbase_q, rbase_d;

  logic             h_act_q, h_act_d;
  logic [CW-1:0]    col_q, col_d;
  logic [SW-1:0]    csub_q, csub_d;
  logic             h_cur;
  logic [CW-1:0]    col_cur;
  logic [SW-1:0]    csub_cur;

  logic [AW-1:0]    addr_q, addr_d;
  logic             line_chg, latch;

  logic [ROM_LAT:0]       hit_sr_q;
  logic [ROM_LAT:0]       blank_sr_q;
  logic [ROM_LAT:0][11:0] bg_sr_q;

  logic [3:0] red_q, red_d;
  logic [3:0] grn_q, grn_d;
  logic [3:0] blu_q, blu_d;
  logic       hit_q, hit_d;

  // Frame latch and vertical tracking; the latched values are usable
  // on the very line-0 change that captures them.
  always_comb begin
    line_chg = DrawY != drawy_q;
    latch    = line_chg && (DrawY == '0);
    armed_d  = armed_q | latch;
    px_d     = latch ? pos_x : px_q;
    py_d     = latch ? pos_y : py_q;
    sel_d    = latch ? sprite_sel : sel_q;
    v_act_d  = v_act_q;
    row_d    = row_q;
    rsub_d   = rsub_q;
    rbase_d  = rbase_q;
    if (line_chg && armed_d) begin
      if (DrawY == py_d) begin
        v_act_d = 1'b1;
        row_d   = '0;
        rsub_d  = '0;
        rbase_d = AW'(32'(sel_d) * SPR_SZ);
      end else if (latch) begin
        v_act_d = 1'b0;
      end else if (v_act_q) begin
        if (rsub_q == SMAX) begin
          rsub_d = '0;
          if (row_q == RMAX) begin
            v_act_d = 1'b0;
          end else begin
            row_d   = row_q + RW'(1);
            rbase_d = rbase_q + W_A;
          end
        end else begin
          rsub_d = rsub_q + SW'(1);
        end
      end
    end
  end

  // Horizontal tracking: *_cur describes the pixel on DrawX this cycle.
  always_comb begin
    h_cur    = 1'b0;
    col_cur  = col_q;
    csub_cur = csub_q;
    if (v_act_d && blank && DrawX == px_d) begin
      h_cur    = 1'b1;
      col_cur  = '0;
      csub_cur = '0;
    end else if (!line_chg && blank) begin
      h_cur = h_act_q;
    end
    h_act_d = h_cur;
    col_d   = col_cur;
    csub_d  = csub_cur;
    if (h_cur) begin
      if (csub_cur == SMAX) begin
        csub_d = '0;
        if (col_cur == CMAX) h_act_d = 1'b0;
        else col_d = col_cur + CW'(1);
      end else begin
        csub_d = csub_cur + SW'(1);
      end
    end
    addr_d = rbase_d + AW'(col_cur);
  end

  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    hit_d = 1'b0;
    if (!blank_sr_q[ROM_LAT]) begin
      hit_d = 1'b0;
    end else if (hit_sr_q[ROM_LAT] && rom_q != TRANSPARENT_IDX) begin
      red_d = pal_red;
      grn_d = pal_green;
      blu_d = pal_blue;
      hit_d = 1'b1;
    end else begin
      {red_d, grn_d, blu_d} = bg_sr_q[ROM_LAT];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      drawy_q    <= '0;
      armed_q    <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      sel_q      <= '0;
      v_act_q    <= 1'b0;
      row_q      <= '0;
      rsub_q     <= '0;
      rbase_q    <= '0;
      h_act_q    <= 1'b0;
      col_q      <= '0;
      csub_q     <= '0;
      addr_q     <= '0;
      hit_sr_q   <= '0;
      blank_sr_q <= '0;
      bg_sr_q    <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
      hit_q      <= 1'b0;
    end else begin
      drawy_q       <= DrawY;
      armed_q       <= armed_d;
      px_q          <= px_d;
      py_q          <= py_d;
      sel_q         <= sel_d;
      v_act_q       <= v_act_d;
      row_q         <= row_d;
      rsub_q        <= rsub_d;
      rbase_q       <= rbase_d;
      h_act_q       <= h_act_d;
      col_q         <= col_d;
      csub_q        <= csub_d;
      addr_q        <= addr_d;
      hit_sr_q[0]   <= h_cur;
      blank_sr_q[0] <= blank;
      bg_sr_q[0]    <= {bg_red, bg_green, bg_blue};
      for (int i = 1; i <= ROM_LAT; i++) begin
        hit_sr_q[i]   <= hit_sr_q[i-1];
        blank_sr_q[i] <= blank_sr_q[i-1];
        bg_sr_q[i]    <= bg_sr_q[i-1];
      end
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
      hit_q <= hit_d;
    end
  end

  assign rom_addr   = addr_q;
  assign pal_idx    = rom_q;
  assign red        = red_q;
  assign green      = grn_q;
  assign blue       = blu_q;
  assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (SCALE 1 and 2) on one raster,
// scored against a pixel-coordinate model of the sprite window.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [3:0] bgr, bgg, bgb;

  logic [9:0]  px_in [2];
  logic [9:0]  py_in [2];
  logic [3:0]  sel_in[2];
  logic [15:0] addr_o[2];
  logic [3:0]  rq    [2];
  logic [3:0]  pal_o [2];
  logic [3:0]  pr    [2];
  logic [3:0]  pg    [2];
  logic [3:0]  pb    [2];
  logic [3:0]  r_o   [2];
  logic [3:0]  g_o   [2];
  logic [3:0]  b_o   [2];
  logic        hit_o [2];

  logic [3:0] rom_mem [0:65535];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    sprite_blitter #(.SCALE(i + 1)) u_dut (
      .vga_clk   (clk),
      .reset_n   (rst_n),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .blank     (blank),
      .pos_x     (px_in[i]),
      .pos_y     (py_in[i]),
      .sprite_sel(sel_in[i]),
      .bg_red    (bgr),
      .bg_green  (bgg),
      .bg_blue   (bgb),
      .rom_addr  (addr_o[i]),
      .rom_q     (rq[i]),
      .pal_idx   (pal_o[i]),
      .pal_red   (pr[i]),
      .pal_green (pg[i]),
      .pal_blue  (pb[i]),
      .red       (r_o[i]),
      .green     (g_o[i]),
      .blue      (b_o[i]),
      .sprite_hit(hit_o[i])
    );
    assign pr[i] = ~pal_o[i];
    assign pg[i] = pal_o[i] ^ 4'h9;
    assign pb[i] = pal_o[i] + 4'd3;
    always @(posedge clk) rq[i] <= rom_mem[addr_o[i]];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state (frame-latched copies, per-line scan state)
  int  lpx[2], lpy[2], lsel[2];
  bit  armed[2], line_ok[2];
  int  prev_y;
  int  sc[2] = '{1, 2};
  bit          av [2][8];
  int          ea [2][8];
  bit          rv [2][8];
  logic [12:0] erg[2][8];
  int  obs_hits[2], exp_hits[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      armed[i] = 0;
      line_ok[i] = 0;
      for (int j = 0; j < 8; j++) begin
        av[i][j] = 0;
        rv[i][j] = 0;
      end
    end
    prev_y = 0;
  endfunction

  task automatic tick(input int x, input int y, input bit b,
                      input logic [11:0] bg);
    int pa, pc, dx, dy, a, s;
    bit inn;
    logic [3:0] idx;
    @(negedge clk);
    pa = (cyc + 7) % 8;
    pc = (cyc + 5) % 8;
    for (int i = 0; i < 2; i++) begin
      if (av[i][pa]) begin
        checks++;
        if (addr_o[i] !== 16'(ea[i][pa])) begin
          errors++;
          $display("FAIL addr dut%0d cyc %0d: got %0d exp %0d",
                   i, cyc - 1, addr_o[i], ea[i][pa]);
        end
      end
      if (rv[i][pc]) begin
        checks++;
        if (hit_o[i] === 1'b1) obs_hits[i]++;
        if ({hit_o[i], r_o[i], g_o[i], b_o[i]} !== erg[i][pc]) begin
          errors++;
          $display("FAIL pixel dut%0d cyc %0d: got %h exp %h", i, cyc - 3,
                   {hit_o[i], r_o[i], g_o[i], b_o[i]}, erg[i][pc]);
        end
      end
    end
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    {bgr, bgg, bgb} = bg;
    if (y != prev_y) begin
      for (int i = 0; i < 2; i++) begin
        line_ok[i] = 0;
        if (y == 0) begin
          lpx[i]  = int'(px_in[i]);
          lpy[i]  = int'(py_in[i]);
          lsel[i] = int'(sel_in[i]);
          armed[i] = 1;
        end
      end
    end
    prev_y = y;
    for (int i = 0; i < 2; i++) begin
      s  = sc[i];
      dx = x - lpx[i];
      dy = y - lpy[i];
      if (!b) line_ok[i] = 0;
      else if (armed[i] && dx == 0 && dy >= 0 && dy < 60 * s) line_ok[i] = 1;
      inn = line_ok[i] && dx >= 0 && dx < 60 * s;
      a = inn ? lsel[i] * 3600 + (dy / s) * 60 + dx / s : 0;
      idx = rom_mem[a];
      av[i][cyc % 8] = inn;
      ea[i][cyc % 8] = a;
      rv[i][cyc % 8] = 1;
      if (!b) erg[i][cyc % 8] = '0;
      else if (inn && idx != 4'd0) begin
        erg[i][cyc % 8] = {1'b1, ~idx, idx ^ 4'h9, idx + 4'd3};
        exp_hits[i]++;
      end else erg[i][cyc % 8] = {1'b0, bg};
    end
    cyc++;
  endtask

  task automatic line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) tick(x, y, 1'b1, 12'($urandom));
  endtask

  task automatic vsync();
    for (int i = 0; i < 2; i++) begin
      obs_hits[i] = 0;
      exp_hits[i] = 0;
    end
    tick(0, 524, 1'b0, 12'h0);
    tick(1, 524, 1'b0, 12'h0);
  endtask

  task automatic drain_and_count(input string tag);
    for (int k = 0; k < 4; k++) tick(700, prev_y, 1'b0, 12'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_hits[i] !== exp_hits[i]) begin
        errors++;
        $display("FAIL %s hits dut%0d: got %0d exp %0d",
                 tag, i, obs_hits[i], exp_hits[i]);
      end
    end
  endtask

  task automatic test_reset_state();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({addr_o[i], hit_o[i], r_o[i], g_o[i], b_o[i]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h exp 0", i,
                 {addr_o[i], hit_o[i], r_o[i], g_o[i], b_o[i]});
      end
    end
  endtask

  task automatic test_reset_midline();
    px_in[0] = 10'd100; py_in[0] = 10'd50; sel_in[0] = 4'd2;
    px_in[1] = 10'd0;   py_in[1] = 10'd0;  sel_in[1] = 4'd0;
    vsync();
    for (int y = 0; y <= 51; y++) line(y, 95, 125);
    line(52, 95, 120);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({addr_o[i], hit_o[i], r_o[i], g_o[i], b_o[i]} !== '0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h exp 0", i,
                 {addr_o[i], hit_o[i], r_o[i], g_o[i], b_o[i]});
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    obs_hits[0] = 0;
    exp_hits[0] = 0;
    for (int y = 53; y <= 60; y++) line(y, 95, 125);
    for (int k = 0; k < 4; k++) tick(700, 60, 1'b0, 12'h0);
    checks++;
    if (obs_hits[0] !== 0) begin
      errors++;
      $display("FAIL no_draw_after_reset: got %0d hits exp 0", obs_hits[0]);
    end
  endtask

  task automatic test_scale();
    bit b;
    logic [11:0] bg;
    px_in[0] = 10'd100; py_in[0] = 10'd50; sel_in[0] = 4'd2;
    px_in[1] = 10'd0;   py_in[1] = 10'd0;  sel_in[1] = 4'd0;
    rom_mem[7201] = 4'd0;
    rom_mem[7202] = 4'd7;
    vsync();
    for (int y = 0; y <= 121; y++) begin
      for (int x = 0; x <= 165; x++) begin
        b  = !(y == 60 && x == 130);
        bg = (y == 50 && x == 101) ? 12'hA53 : 12'($urandom);
        tick(x, y, b, bg);
        if (y == 50 && (x == 101 || x == 160)) begin
          checks++;
          if (addr_o[0] !== ((x == 101) ? 16'd7200 : 16'd7259)) begin
            errors++;
            $display("FAIL s1_addr x%0d: got %0d", x - 1, addr_o[0]);
          end
        end
        if (y == 51 && x == 101) begin
          checks++;
          if (addr_o[0] !== 16'd7260) begin
            errors++;
            $display("FAIL s1_line51: got %0d exp 7260", addr_o[0]);
          end
        end
        if (y <= 4 && x == 1) begin
          checks++;
          if (addr_o[1] !== 16'(60 * (y / 2))) begin
            errors++;
            $display("FAIL s2_linestart y%0d: got %0d exp %0d",
                     y, addr_o[1], 60 * (y / 2));
          end
        end
        if (y == 0 && x == 3) begin
          checks++;
          if (addr_o[1] !== 16'd1) begin
            errors++;
            $display("FAIL s2_dup: got %0d exp 1", addr_o[1]);
          end
        end
        if (y == 50 && x == 104) begin
          checks++;
          if ({hit_o[0], r_o[0], g_o[0], b_o[0]} !== 13'h0A53) begin
            errors++;
            $display("FAIL transparent: got %h exp 0a53",
                     {hit_o[0], r_o[0], g_o[0], b_o[0]});
          end
        end
        if (y == 50 && x == 105) begin
          checks++;
          if ({hit_o[0], r_o[0], g_o[0], b_o[0]} !== 13'h18EA) begin
            errors++;
            $display("FAIL opaque: got %h exp 18ea",
                     {hit_o[0], r_o[0], g_o[0], b_o[0]});
          end
        end
        if (y == 60 && x == 133) begin
          checks++;
          if ({hit_o[0], r_o[0], g_o[0], b_o[0]} !== 13'h0) begin
            errors++;
            $display("FAIL blanked: got %h exp 0",
                     {hit_o[0], r_o[0], g_o[0], b_o[0]});
          end
        end
      end
    end
    drain_and_count("scale");
  endtask

  task automatic test_frame_latch();
    px_in[0] = 10'd100; py_in[0] = 10'd50; sel_in[0] = 4'($urandom_range(0, 11));
    px_in[1] = 10'($urandom_range(90, 100));
    py_in[1] = 10'($urandom_range(0, 20));
    sel_in[1] = 4'($urandom_range(0, 11));
    vsync();
    for (int y = 0; y <= 111; y++) begin
      if (y == 30) begin
        px_in[0] = 10'd200;
        sel_in[0] = 4'($urandom_range(0, 11));
      end
      line(y, 90, 170);
    end
    drain_and_count("latch_old");
    vsync();
    for (int y = 0; y <= 111; y++) line(y, 190, 270);
    drain_and_count("latch_new");
    checks++;
    if (obs_hits[0] == 0) begin
      errors++;
      $display("FAIL latch_new_pos: got 0 hits exp >0");
    end
  endtask

  task automatic test_clip();
    px_in[0] = 10'd620; py_in[0] = 10'd10; sel_in[0] = 4'($urandom_range(0, 11));
    px_in[1] = 10'd630; py_in[1] = 10'd11; sel_in[1] = 4'($urandom_range(0, 11));
    vsync();
    for (int y = 0; y <= 14; y++) begin
      for (int x = 0; x <= 5; x++) begin
        tick(x, y, 1'b1, 12'($urandom));
        if (y == 11 && x == 3) begin
          checks++;
          if (hit_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL clip_wrap: got hit %b exp 0", hit_o[0]);
          end
        end
      end
      for (int x = 600; x <= 650; x++) tick(x, y, x < 640, 12'($urandom));
    end
    drain_and_count("clip");
  endtask

  initial begin
    rst_n = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    bgr = '0; bgg = '0; bgb = '0;
    for (int i = 0; i < 2; i++) begin
      px_in[i] = '0; py_in[i] = '0; sel_in[i] = '0;
      obs_hits[i] = 0; exp_hits[i] = 0;
    end
    for (int a = 0; a < 65536; a++)
      rom_mem[a] = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    test_reset_state();
    rst_n = 1'b1;
    test_reset_midline();
    test_scale();
    test_frame_latch();
    test_clip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
